// File: rtl/sig_playback.sv
// Record-then-replay engine: captures a burst of samples into a single-clock RAM,
// then streams it back out on valid/ready with prefetch and a one-entry skid buffer.
module sig_playback #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     rec,
    input  logic                     play,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [ADDRESS_WIDTH-1:0] len,
    input  logic [DATA_WIDTH-1:0]    mic_signal,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

    localparam logic [ADDRESS_WIDTH:0]   FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0]   COUNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE    = COUNT_ONE[ADDRESS_WIDTH-1:0];

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic [1:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDRESS_WIDTH-1:0] rdPtr_q, rdPtr_d;
    logic [ADDRESS_WIDTH:0]   target_q, target_d;
    logic [ADDRESS_WIDTH:0]   recCount_q, recCount_d;
    logic                     fetchDone_q, fetchDone_d;
    logic                     rdValid_q, rdValid_d;
    logic [DATA_WIDTH-1:0]    rdData_q;
    logic                     skidValid_q, skidValid_d;
    logic [DATA_WIDTH-1:0]    skidData_q, skidData_d;
    logic                     outValid_q, outValid_d;
    logic [DATA_WIDTH-1:0]    outData_q, outData_d;
    logic                     done_q, done_d;

    logic                     memWrite;
    logic                     readIssue;
    logic [ADDRESS_WIDTH-1:0] readAddr;
    logic                     rdTaken;
    logic                     outFree;
    logic                     canIssue;
    logic                     wrLast;

    assign outFree  = !outValid_q || out_ready;
    // A new read may only be issued while at least one of the three pipeline slots is free.
    assign canIssue = !(rdValid_q && skidValid_q && outValid_q);
    assign wrLast   = (({1'b0, wrPtr_q} + COUNT_ONE) == target_q);

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        target_d    = target_q;
        recCount_d  = recCount_q;
        fetchDone_d = fetchDone_q;
        rdValid_d   = rdValid_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        done_d      = 1'b0;
        memWrite    = 1'b0;
        readIssue   = 1'b0;
        readAddr    = rdPtr_q;
        rdTaken     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                readAddr = '0;
                if (rec) begin
                    target_d = (len == '0) ? FULL_COUNT : {1'b0, len};
                    wrPtr_d  = '0;
                    state_d  = ST_RECORD;
                end else if (play) begin
                    if (recCount_q != '0) begin
                        readIssue   = 1'b1;
                        rdValid_d   = 1'b1;
                        skidValid_d = 1'b0;
                        outValid_d  = 1'b0;
                        fetchDone_d = 1'b0;
                        state_d     = ST_PLAY;
                    end else begin
                        done_d = !done_q;
                    end
                end
            end

            ST_RECORD: begin
                if (en) begin
                    memWrite = 1'b1;
                    wrPtr_d  = wrPtr_q + PTR_ONE;
                    if (wrLast) begin
                        recCount_d = target_q;
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                    end else if (stop) begin
                        recCount_d = {1'b0, wrPtr_q} + COUNT_ONE;
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                    end
                end else if (stop) begin
                    recCount_d = {1'b0, wrPtr_q};
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                end
            end

            ST_PLAY: begin
                if (stop) begin
                    rdValid_d   = 1'b0;
                    skidValid_d = 1'b0;
                    outValid_d  = 1'b0;
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                end else begin
                    // Output drains the skid first so ordering is preserved across stalls.
                    if (outFree) begin
                        if (skidValid_q) begin
                            outData_d   = skidData_q;
                            outValid_d  = 1'b1;
                            skidData_d  = rdData_q;
                            skidValid_d = rdValid_q;
                            rdTaken     = rdValid_q;
                        end else if (rdValid_q) begin
                            outData_d  = rdData_q;
                            outValid_d = 1'b1;
                            rdTaken    = 1'b1;
                        end else begin
                            outValid_d = 1'b0;
                        end
                    end else if (rdValid_q && !skidValid_q) begin
                        skidData_d  = rdData_q;
                        skidValid_d = 1'b1;
                        rdTaken     = 1'b1;
                    end
                    rdValid_d = rdValid_q && !rdTaken;
                    if (!fetchDone_q && canIssue) begin
                        readIssue = 1'b1;
                        rdValid_d = 1'b1;
                    end
                    if (fetchDone_q && !rdValid_d && !skidValid_d && !outValid_d) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Loop is sampled when the last address of the buffer is fetched.
        if (readIssue) begin
            if (({1'b0, readAddr} + COUNT_ONE) == recCount_q) begin
                rdPtr_d     = '0;
                fetchDone_d = !loop;
            end else begin
                rdPtr_d = readAddr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && memWrite) begin
            mem[wrPtr_q] <= mic_signal;
        end
        if (rst && readIssue) begin
            rdData_q <= mem[readAddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            target_q    <= '0;
            recCount_q  <= '0;
            fetchDone_q <= 1'b0;
            rdValid_q   <= 1'b0;
            skidValid_q <= 1'b0;
            skidData_q  <= '0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            target_q    <= target_d;
            recCount_q  <= recCount_d;
            fetchDone_q <= fetchDone_d;
            rdValid_q   <= rdValid_d;
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            done_q      <= done_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: doc/sig_playback.md
Name: sig_playback

Overview:
- Record-then-replay engine for the signal-generation lab chain.
- Writes a burst of `mic_signal` samples into an internal single-clock RAM on command.
- Later reads the burst back out in order on a valid/ready stream.
- It is the reader-side counterpart to the continuous write/offset-read delay path: it owns both RAM ports and sequences them with an FSM instead of a free-running offset.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- ADDRESS_WIDTH, 8, RAM address width; depth = 2**ADDRESS_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  sample strobe; a sample is captured only on cycles with en=1 while recording.
- rec  input  1  start-record request, sampled in IDLE.
- play  input  1  start-playback request, sampled in IDLE.
- stop  input  1  abort current RECORD or PLAY.
- loop  input  1  playback wraps to address 0 at end instead of finishing.
- len  input  ADDRESS_WIDTH  record length in samples; 0 means full depth (2**ADDRESS_WIDTH).
- mic_signal  input  DATA_WIDTH  sample to record.
- out_data  output  DATA_WIDTH  playback sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the sample.
- busy  output  1  high in RECORD or PLAY.
- done  output  1  one-cycle pulse when a record or playback completes or is stopped.

Behaviour:
- **Reset (rst=0 at a clk edge):**
  - State goes to IDLE.
  - out_data=0, out_valid=0, busy=0, done=0.
  - Stored length rec_count=0 and all pointers cleared.
  - RAM contents are not cleared.
  - Reset takes priority over every other input, including mid-RECORD and mid-PLAY.
- **FSM states:** IDLE, RECORD, PLAY.
- **IDLE:**
  - rec=1: latch len as target, wr_ptr=0, go to RECORD. rec has priority over play.
  - rec=0, play=1, rec_count!=0: rd_ptr=0, go to PLAY.
  - rec=0, play=1, rec_count==0: stay in IDLE and pulse done on the next cycle.
  - stop is ignored in IDLE.
- **RECORD:**
  - Each cycle with en=1 writes mic_signal to RAM[wr_ptr] and increments wr_ptr.
  - Completion is the write of sample number target (target = 2**ADDRESS_WIDTH when len=0).
  - On completion: rec_count=target, next state IDLE, done=1 for the following cycle.
  - stop=1 with no write that cycle: rec_count=wr_ptr (samples written so far), go to IDLE, pulse done.
  - stop=1 and en=1 in the same cycle: the write occurs first and is counted.
  - rec/play are ignored while busy.
- **PLAY:**
  - RAM read is synchronous with 1-cycle latency.
  - First out_valid is asserted 2 cycles after the cycle play was sampled.
  - A transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
  - Sustained throughput is 1 sample/cycle when out_ready is held high. This requires prefetch plus a one-entry skid register.
  - Samples are emitted for addresses 0..rec_count-1 in order.
  - After the last sample transfers:
    - loop=0: out_valid drops the next cycle, go to IDLE, pulse done.
    - loop=1: continue from address 0 with no bubble.
  - loop is sampled at each end-of-buffer.
  - stop=1: out_valid drops the next cycle, any prefetched data is discarded, go to IDLE, pulse done. The sample transferring in the stop cycle counts as delivered.
- **Status outputs:**
  - busy=1 exactly while the state is RECORD or PLAY.
  - done is never high for more than one cycle.
- **Arithmetic:**
  - Pointers are ADDRESS_WIDTH bits and wrap modulo depth.
  - rec_count is ADDRESS_WIDTH+1 bits so it can hold the full depth.

Test Plan:
- **Reset mid-PLAY:** rst=0 for 1 cycle during PLAY -> out_valid=0, busy=0, done=0 next cycle; a subsequent play pulse gives an immediate done (rec_count=0).
- **Record then play:** len=4, rec, en=1 for 4 cycles with mic_signal 0x11,0x22,0x33,0x44 -> done 1 cycle after the 4th write. Then play with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles; out_valid first high 2 cycles after play; done after the last sample.
- **Backpressure:** same buffer, out_ready toggled 1,0,0,1,... -> every sample delivered exactly once and in order; out_data stable while stalled.
- **Gapped en and stop:** len=8, en high on alternate cycles, stop after 3 writes -> rec_count=3; playback yields exactly those 3 samples.
- **Full depth and loop:** len=0 with ADDRESS_WIDTH=4 records 16 samples (0..15). Play with loop=1 -> stream 0..15,0,1,... with no bubble at the wrap. Deassert loop -> finishes at 15, done pulses.
- **Priority:** rec and play both high in IDLE -> enters RECORD; play pulse while busy is ignored.
